limbus_sys_acortex_st_arbiter: RTL
==================================

// Module: limbus_sys_acortex_st_arbiter
// PURPOSE
//  Round-robin burst arbiter sharing the single 32-bit acortex Avalon-ST sink between NUM_REQ sources.
//  Sits directly upstream of the acortex ST timing adaptor and drives its in_valid/in_data from the granted source.
//  Grant is held for up to BURST_MAX beats, then rotates, so no source can starve the audio path.
// PARAMETERS
//  NUM_REQ    4   number of requesting sources (2..8)
//  DATA_W     32  stream payload width
//  BURST_MAX  8   max beats per grant (1..255)
// PORTS
//  clk          in   1                  single clock, all logic rising-edge
//  reset        in   1                  synchronous, active-high reset
//  arb_en       in   1                  1 = new grants allowed; 0 = finish current burst, then idle
//  req_mask     in   NUM_REQ            1 = source enabled for arbitration
//  in_valid     in   NUM_REQ            per-source valid
//  in_data      in   NUM_REQ*DATA_W     per-source payload, source i at [i*DATA_W +: DATA_W]
//  in_ready     out  NUM_REQ            per-source ready; only granted bit can be 1
//  out_valid    out  1                  to timing adaptor in_valid
//  out_data     out  DATA_W             to timing adaptor in_data
//  out_channel  out  clog2(NUM_REQ)     index of source driving out_data
//  out_ready    in   1                  from timing adaptor in_ready
//  busy         out  1                  1 while in GRANT
// BEHAVIOUR
//  Reset values: state=IDLE, grant=0, last_grant=NUM_REQ-1 (source 0 has top priority after reset),
//   beat_cnt=0; outputs in_ready=0, out_valid=0, out_data=0, out_channel=0, busy=0.
//  FSM states:
//   IDLE:
//    eligible = in_valid & req_mask.
//    If arb_en && |eligible: pick the first eligible index searching last_grant+1 upward, wrapping modulo NUM_REQ.
//    Register grant=pick, beat_cnt=0, go to GRANT.
//    IDLE costs exactly 1 bubble cycle per handover.
//   GRANT:
//    out_valid=in_valid[grant]; out_data=in_data[grant]; out_channel=grant.
//    in_ready[grant]=out_ready; all other in_ready bits are 0.
//    Beat = out_valid && out_ready; each beat increments beat_cnt (8-bit).
//    Exit to IDLE with last_grant=grant when either holds:
//     (a) a beat occurs with beat_cnt==BURST_MAX-1, or
//     (b) in_valid[grant]==0 in this cycle (source paused; grant released, no beat lost).
//  Outputs in_ready, out_valid, out_data and out_channel are combinational from registered state.
//   In IDLE they are forced to 0; no data passes in IDLE.
//  Latency: source valid -> out_valid = 1 clk (IDLE arbitration), then 0 per beat while granted.
//  Handshake: no transfer is ever accepted without out_ready=1. Valid is never asserted for a non-granted source.
//  arb_en deasserted in GRANT does not truncate the burst; it only blocks the next IDLE pick.
//  req_mask bit cleared in GRANT for the granted source: burst continues; mask only gates new grants.
//  Single eligible source: re-granted after 1 bubble each BURST_MAX beats (rotation includes self).
//  Simultaneous burst end (a) and in_valid drop: the beat counts, exit once.
//  Reset mid-burst: next cycle IDLE, in_ready=0, partial burst abandoned. Source data is not consumed
//   because ready was 0 in the reset cycle.
//  out_channel is held stable for the whole GRANT tenure.
// STRUCTURE
//  Package limbus_sys_acortex_pkg:
//   - state enum {IDLE, GRANT}
//   - CH_W = clog2(NUM_REQ) function
//   - BEAT_CNT_W=8 constant
//  Sub-module limbus_sys_acortex_rr_pick: combinational rotate-priority encoder.
//   Inputs: eligible, last_grant. Outputs: pick, pick_vld.
//  Top level holds FSM, grant/last_grant/beat_cnt registers and the output mux.
// TESTING
//  1. Reset, all 4 sources valid, out_ready=1, BURST_MAX=8
//     -> grants 0,1,2,3,0 in order; 8 beats each; 1 idle cycle between; out_channel matches.
//  2. Only source 2 valid, out_ready=1
//     -> 8 beats, 1 bubble, 8 beats; in_ready[0,1,3] stay 0 throughout.
//  3. Source 1 granted, drops in_valid after beat 3
//     -> IDLE next cycle, last_grant=1, next pick = source 2 if valid.
//  4. out_ready toggled 1010 during grant
//     -> beats only on out_ready=1; beat_cnt reaches 8 only after 8 accepted beats; no duplicate or lost data.
//  5. arb_en=0 asserted at beat 4 of source 0
//     -> beats 5..8 complete, then IDLE with no new grant until arb_en=1.
//  6. reset pulsed at beat 5 of source 3
//     -> in_ready/out_valid 0 next cycle; after release, source 0 granted first.

Source files
------------

// File: rtl/limbus_sys_acortex_pkg.sv
// Shared types and constants for the acortex Avalon-ST arbiter slice.
//   arb_state_e : arbiter FSM state (IDLE / GRANT)
//   BEAT_CNT_W  : width of the per-grant beat counter
//   ch_w()      : channel index width for a given source count (min 1)
package limbus_sys_acortex_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int BEAT_CNT_W = 8;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/limbus_sys_acortex_rr_pick.sv
// Combinational rotate-priority encoder.
//   eligible_i   : request vector, one bit per source
//   last_grant_i : source granted most recently; search starts one above it
//   pick_o       : first eligible index found, wrapping modulo NUM_REQ
//   pick_vld_o   : 1 when any source is eligible
module limbus_sys_acortex_rr_pick
    import limbus_sys_acortex_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CH_W    = ch_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible_i,
    input  logic [CH_W-1:0]    last_grant_i,
    output logic [CH_W-1:0]    pick_o,
    output logic               pick_vld_o
);

    // Walk the rotation from farthest to nearest so the nearest eligible
    // source (smallest offset from last_grant) is the one left standing.
    // Offset NUM_REQ lands back on last_grant itself, so a lone requester
    // is re-granted.
    always_comb begin
        pick_o     = '0;
        pick_vld_o = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (eligible_i[(int'(last_grant_i) + k) % NUM_REQ]) begin
                pick_o     = CH_W'((int'(last_grant_i) + k) % NUM_REQ);
                pick_vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/limbus_sys_acortex_st_arbiter.sv
// Round-robin burst arbiter sharing the 32-bit acortex Avalon-ST sink
// between NUM_REQ sources. A grant lasts up to BURST_MAX beats or until the
// granted source drops valid; each handover costs one IDLE bubble.
//   clk_i / reset_i : clock, synchronous active-high reset
//   arb_en_i        : allow new grants (does not cut a running burst)
//   req_mask_i      : per-source arbitration enable
//   in_valid_i      : per-source valid
//   in_data_i       : per-source payload, source i at [i*DATA_W +: DATA_W]
//   in_ready_o      : per-source ready, only the granted bit may be set
//   out_valid_o / out_data_o / out_channel_o / out_ready_i : sink side
//   busy_o          : 1 while a grant is held
module limbus_sys_acortex_st_arbiter
    import limbus_sys_acortex_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 8,
    localparam int CH_W     = ch_w(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      arb_en_i,
    input  logic [NUM_REQ-1:0]        req_mask_i,
    input  logic [NUM_REQ-1:0]        in_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] in_data_i,
    output logic [NUM_REQ-1:0]        in_ready_o,
    output logic                      out_valid_o,
    output logic [DATA_W-1:0]         out_data_o,
    output logic [CH_W-1:0]           out_channel_o,
    input  logic                      out_ready_i,
    output logic                      busy_o
);

    arb_state_e            state_q;
    logic [CH_W-1:0]       grant_q;
    logic [CH_W-1:0]       last_grant_q;
    logic [BEAT_CNT_W-1:0] beat_cnt_q;
    logic [BEAT_CNT_W-1:0] beat_cnt_d;

    logic [NUM_REQ-1:0]    eligible;
    logic [CH_W-1:0]       pick;
    logic                  pick_vld;
    logic                  cur_valid;
    logic                  beat;
    logic                  burst_done;

    assign eligible = in_valid_i & req_mask_i;

    limbus_sys_acortex_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .CH_W    (CH_W)
    ) u_pick (
        .eligible_i   (eligible),
        .last_grant_i (last_grant_q),
        .pick_o       (pick),
        .pick_vld_o   (pick_vld)
    );

    assign cur_valid  = in_valid_i[grant_q];
    assign beat       = (state_q == GRANT) && cur_valid && out_ready_i;
    assign burst_done = beat && (beat_cnt_q == BEAT_CNT_W'(BURST_MAX - 1));
    assign beat_cnt_d = beat ? beat_cnt_q + 1'b1 : beat_cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= CH_W'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_en_i && pick_vld) begin
                        state_q    <= GRANT;
                        grant_q    <= pick;
                        beat_cnt_q <= '0;
                    end
                end
                GRANT: begin
                    beat_cnt_q <= beat_cnt_d;
                    // A final beat coinciding with a valid drop is one exit;
                    // a paused source releases the grant without losing data.
                    if (burst_done || !cur_valid) begin
                        state_q      <= IDLE;
                        last_grant_q <= grant_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Valid and ready are also held low while reset is asserted, so a burst
    // cut by reset never hands over a beat in the reset cycle itself.
    always_comb begin
        in_ready_o    = '0;
        out_valid_o   = 1'b0;
        out_data_o    = '0;
        out_channel_o = '0;
        if (state_q == GRANT) begin
            out_data_o    = in_data_i[grant_q*DATA_W +: DATA_W];
            out_channel_o = grant_q;
            if (!reset_i) begin
                out_valid_o         = cur_valid;
                in_ready_o[grant_q] = out_ready_i;
            end
        end
    end

    assign busy_o = (state_q == GRANT);

endmodule
